// File: rtl/aes_inv_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 decryption core.
// Contents: state_t FSM encoding, NR / RKA_W / RK_LAST constants, and the
// byte-level functions gmul, ginv, sub_byte, inv_shift_rows, inv_mix_columns.
// State words use FIPS-197 column-major order: byte i (i = row + 4*col)
// sits at bits [127-8i -: 8].
package aes_inv_pkg;

  localparam int unsigned NR      = 10;
  localparam int unsigned RKA_W   = 4;
  localparam logic [3:0]  RK_LAST = 4'd10;

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

  // GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (2+4+...+128); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // Byte-substitution cell; inv selects the inverse S-box.
  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    logic [7:0] t;
    logic [7:0] res;
    if (inv) begin
      t   = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
      res = ginv(t);
    end else begin
      t   = ginv(b);
      res = t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
    end
    return res;
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c-r+4)%4))) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c)   +: 8];
      a1 = s[8*(14-4*c)   +: 8];
      a2 = s[8*(13-4*c)   +: 8];
      a3 = s[8*(12-4*c)   +: 8];
      o[8*(15-4*c) +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[8*(14-4*c) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[8*(13-4*c) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[8*(12-4*c) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round.
// Ports: data (state in), rk (round key), last (skip InvMixColumns), next (state out).
// Order: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (unless last).
module aes_inv_round
  import aes_inv_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] next
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;

  assign shifted = inv_shift_rows(data);

  // 16 substitution cells, direction fixed to inverse.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign subbed[8*i +: 8] = sub_byte(shifted[8*i +: 8], 1'b1);
  end

  assign keyed = subbed ^ rk;
  assign next  = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-128 decryption core, one round per clock.
// Ports: clk, reset (async, active-high), in_valid/in_ready/ct (ciphertext in),
//        rk_addr/rk_data (external key store, 1-cycle registered read),
//        out_valid/out_ready/pt (plaintext out).
// Option: define AES_INV_ABORT_EN to add a synchronous abort input that
//         returns the core to IDLE and discards any in-flight block.
module aes_inv_cipher_seq
  import aes_inv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
`ifdef AES_INV_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     ct,
  output logic [RKA_W-1:0] rk_addr,
  input  logic [127:0]     rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     pt
);

  state_t       state;
  logic [127:0] data;
  logic [3:0]   rnd;
  logic [127:0] round_out;
  logic         abort_req;

`ifdef AES_INV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  aes_inv_round u_round (
    .data (data),
    .rk   (rk_data),
    .last (state == FINAL),
    .next (round_out)
  );

  assign in_ready = (state == IDLE) && !reset;

  // Address runs one step ahead of the round that consumes it (registered store).
  always_comb begin
    rk_addr = RK_LAST;
    case (state)
      INIT:    rk_addr = RK_LAST - 4'd1;
      ROUND:   rk_addr = rnd - 4'd1;
      FINAL:   rk_addr = 4'd0;
      default: rk_addr = RK_LAST;
    endcase
  end

  // Control FSM, datapath register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      data      <= '0;
      rnd       <= '0;
      out_valid <= 1'b0;
      pt        <= '0;
    end else if (abort_req) begin
      state     <= IDLE;
      data      <= '0;
      rnd       <= '0;
      out_valid <= 1'b0;
      pt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= ct;
            state <= INIT;
          end
        end
        INIT: begin
          data  <= data ^ rk_data;
          rnd   <= 4'(NR - 1);
          state <= ROUND;
        end
        ROUND: begin
          data <= round_out;
          if (rnd == 4'd1) state <= FINAL;
          else             rnd   <= rnd - 4'd1;
        end
        FINAL: begin
          data      <= round_out;
          pt        <= round_out;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Self-checking bench for aes_inv_cipher_seq.
// Reference: table-driven forward AES-128 (key expansion + encryption) built
// from first principles; the DUT must invert it. FIPS-197 vectors anchor it.
// Define AES_INV_ABORT_EN to also exercise the abort input.
module tb_aes_inv_cipher_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;
`ifdef AES_INV_ABORT_EN
  logic         abort;
`endif

  logic [127:0] ks [0:10];
  logic [7:0]   sbox [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes_inv_cipher_seq dut (
    .clk       (clk),
    .reset     (reset),
`ifdef AES_INV_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt)
  );

  always #5 clk = ~clk;

  // External key store with a registered read port.
  always @(posedge clk) rk_data <= ks[rk_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box via the generator-3 walk: p runs over all nonzero elements, q = 1/p.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  task automatic load_keys(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher using the currently loaded key store.
  function automatic logic [127:0] encrypt(input logic [127:0] ptv);
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = ptv[8*(15-i) +: 8] ^ ks[0][8*(15-i) +: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row+4*c] = t[row+4*((c+row)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[r][8*(15-i) +: 8];
    end
    for (int i = 0; i < 16; i++) res[8*(15-i) +: 8] = s[i];
    return res;
  endfunction

  // One block: call at a negedge with the DUT in IDLE. Returns at the negedge
  // after the output handshake.
  task automatic run_block(input string name, input logic [127:0] ctv, input logic [127:0] exp,
                           input int stall, input bit hold, input bit glitch);
    logic [127:0] held;
    in_valid = 1'b1;
    ct       = ctv;
    check({name, " in_ready at accept"}, 128'(in_ready), 128'(1));
    check({name, " rk_addr at accept"}, 128'(rk_addr), 128'(10));
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k <= 10) check({name, " rk_addr sequence"}, 128'(rk_addr), 128'(10 - k));
      check({name, " busy in_ready/out_valid"}, 128'({in_ready, out_valid}), 128'(0));
      out_ready = 1'($urandom);
      if (glitch && k == 5) begin
        in_valid = 1'b1;
        ct = {$urandom, $urandom, $urandom, $urandom};
      end
      if (glitch && k == 6) in_valid = 1'b0;
      @(negedge clk);
    end
    check({name, " out_valid at T+12"}, 128'(out_valid), 128'(1));
    check({name, " plaintext"}, pt, exp);
    held = pt;
    out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({name, " stall out_valid"}, 128'(out_valid), 128'(1));
      check({name, " stall pt stable"}, pt, held);
      check({name, " stall in_ready"}, 128'(in_ready), 128'(0));
      if (s == stall - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    check({name, " out_valid after handshake"}, 128'(out_valid), 128'(0));
    check({name, " in_ready after handshake"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] key, ptv, ctv;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ct        = '0;
`ifdef AES_INV_ABORT_EN
    abort     = 1'b0;
`endif
    build_sbox();
    load_keys(C1_KEY);

    #1;
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset pt", pt, 128'(0));
    check("reset rk_addr", 128'(rk_addr), 128'(10));
    check("reset in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready after reset", 128'(in_ready), 128'(1));
    @(negedge clk);

    // Reference model anchored on the published vectors.
    check("model C.1 encrypt", encrypt(C1_PT), C1_CT);
    load_keys(B_KEY);
    check("model App.B encrypt", encrypt(B_PT), B_CT);

    // 1: C.1 vector, out_ready high.
    load_keys(C1_KEY);
    run_block("c1", C1_CT, C1_PT, 0, 1'b0, 1'b0);

    // 2: App. B vector, consumer stalls 5 cycles.
    load_keys(B_KEY);
    run_block("appb", B_CT, B_PT, 5, 1'b0, 1'b0);

    // 3: back-to-back with in_valid held high.
    load_keys(C1_KEY);
    run_block("b2b first", C1_CT, C1_PT, 0, 1'b1, 1'b0);
    load_keys(B_KEY);
    run_block("b2b second", B_CT, B_PT, 0, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);

    // 4: reset in ROUND with rnd = 5 (cycle T+6).
    load_keys(C1_KEY);
    in_valid = 1'b1;
    ct = C1_CT;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset rk_addr rnd5", 128'(rk_addr), 128'(4));
    #2 reset = 1'b1;
    #1;
    check("mid-reset out_valid", 128'(out_valid), 128'(0));
    check("mid-reset rk_addr", 128'(rk_addr), 128'(10));
    check("mid-reset pt", pt, 128'(0));
    check("mid-reset in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-reset in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    run_block("after reset", C1_CT, C1_PT, 0, 1'b0, 1'b0);

    // 5: ct change and in_valid pulse while busy.
    load_keys(B_KEY);
    run_block("glitch", B_CT, B_PT, 1, 1'b0, 1'b1);
    for (int k = 0; k < 14; k++) begin
      check("glitch single result", 128'(out_valid), 128'(0));
      @(negedge clk);
    end

    // Randomized keys and plaintexts.
    for (int n = 0; n < 4; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      ptv = {$urandom, $urandom, $urandom, $urandom};
      load_keys(key);
      ctv = encrypt(ptv);
      run_block("random", ctv, ptv, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

`ifdef AES_INV_ABORT_EN
    // 6: abort in FINAL, then in DONE.
    load_keys(C1_KEY);
    in_valid = 1'b1;
    ct = C1_CT;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort FINAL out_valid", 128'(out_valid), 128'(0));
    check("abort FINAL in_ready", 128'(in_ready), 128'(1));
    for (int k = 0; k < 14; k++) begin
      check("abort FINAL no result", 128'(out_valid), 128'(0));
      @(negedge clk);
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (11) @(negedge clk);
    check("abort DONE pre out_valid", 128'(out_valid), 128'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort DONE out_valid", 128'(out_valid), 128'(0));
    check("abort DONE in_ready", 128'(in_ready), 128'(1));
    check("abort DONE pt cleared", pt, 128'(0));
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
